batch_sequencer: RTL

- Owns the coincidence-counting measurement window and generates the periodic `batch_done` strobe that closes a batch in every `count_pulses` channel instance.
- One cycle after each strobe it captures every channel's `reg_count` into a snapshot.
- It then streams the snapshot as a byte frame to the UART transmitter over a valid/ready handshake.
- It sits between the per-channel counters and the host readout path.

---
 rtl/cc_pkg.sv | 28 ++
 rtl/window_timer.sv | 43 ++++
 rtl/batch_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cc_pkg.sv
// Shared definitions for the coincidence-counter readout path: count width,
// frame header, sequencer FSM encoding and small arithmetic helpers.
package cc_pkg;

  localparam int COUNT_W = 8;
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    SEND_HDR = 3'd2,
    SEND_SEQ = 3'd3,
    SEND_CH  = 3'd4,
    DONE     = 3'd5
  } seq_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    logic [COUNT_W-1:0] r;
    if (v == {COUNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/window_timer.sv
// Measurement-window timer: counts 0..WINDOW_CYCLES-1 while enabled and
// emits a registered one-cycle batch_done strobe on the last count.
module window_timer #(
  parameter int WINDOW_CYCLES = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic batch_done
);

  localparam int W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 2;
  localparam logic [W-1:0] LAST = W'(WINDOW_CYCLES - 1);

  logic [W-1:0] win_cnt_q, win_cnt_d;
  logic         batch_done_q;

  // Next window count: clear while disabled, wrap after the last cycle.
  always_comb begin
    win_cnt_d = win_cnt_q;
    if (!enable) begin
      win_cnt_d = '0;
    end else if (win_cnt_q == LAST) begin
      win_cnt_d = '0;
    end else begin
      win_cnt_d = win_cnt_q + W'(1);
    end
  end

  // Counter and strobe registers; strobe is high exactly while the count sits on LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_q    <= '0;
      batch_done_q <= 1'b0;
    end else begin
      win_cnt_q    <= win_cnt_d;
      batch_done_q <= (win_cnt_d == LAST);
    end
  end

  assign batch_done = batch_done_q;

endmodule

// File: rtl/batch_sequencer.sv
// Batch sequencer: closes each measurement window, snapshots all channel
// counts one cycle after the strobe and streams them as a byte frame
// (HEADER, seq_no, ch0..chN-1) over a valid/ready handshake.
module batch_sequencer
  import cc_pkg::*;
#(
  parameter int         NUM_CH        = 4,
  parameter int         WINDOW_CYCLES = 100,
  parameter logic [7:0] HEADER        = HEADER_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_CH*COUNT_W-1:0] reg_count_flat,
  output logic                      batch_done,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic [7:0]                dropped
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  seq_state_e         state_q, state_d;
  logic [CH_W-1:0]    ch_idx_q, ch_idx_d;
  logic [7:0]         seq_no_q, seq_no_d;
  logic [7:0]         frame_seq_q, frame_seq_d;
  logic [7:0]         dropped_q, dropped_d;
  logic [COUNT_W-1:0] snap_q [NUM_CH];
  logic               snap_load_s;
  logic               batch_done_s;
  logic               hs_s;
  logic               overrun_s;

  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               busy_q, busy_d;

  window_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_window_timer (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .batch_done(batch_done_s)
  );

  assign hs_s      = tx_valid_q & tx_ready;
  assign overrun_s = batch_done_s & (state_q != IDLE);

  // FSM next state, frame bookkeeping and overrun accounting.
  always_comb begin
    state_d     = state_q;
    ch_idx_d    = ch_idx_q;
    seq_no_d    = seq_no_q;
    frame_seq_d = frame_seq_q;
    dropped_d   = dropped_q;
    snap_load_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (batch_done_s) begin
          state_d = LATCH;
        end else begin
          state_d = IDLE;
        end
      end
      LATCH: begin
        snap_load_s = 1'b1;
        frame_seq_d = seq_no_q;
        state_d     = SEND_HDR;
      end
      SEND_HDR: begin
        if (hs_s) begin
          state_d = SEND_SEQ;
        end else begin
          state_d = SEND_HDR;
        end
      end
      SEND_SEQ: begin
        if (hs_s) begin
          state_d  = SEND_CH;
          ch_idx_d = '0;
        end else begin
          state_d = SEND_SEQ;
        end
      end
      SEND_CH: begin
        if (hs_s) begin
          if (ch_idx_q == LAST_CH) begin
            state_d = DONE;
          end else begin
            ch_idx_d = ch_idx_q + CH_W'(1);
          end
        end else begin
          state_d = SEND_CH;
        end
      end
      DONE: begin
        seq_no_d = seq_no_q + 8'd1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A strobe arriving outside IDLE is discarded but still consumes a
    // sequence number so the host can see the gap.
    if (overrun_s) begin
      dropped_d = sat_inc(dropped_q);
      seq_no_d  = seq_no_d + 8'd1;
    end else begin
      dropped_d = dropped_d;
    end
  end

  // Output decode from the next state so that tx_valid/tx_data/busy are registered.
  always_comb begin
    tx_valid_d = 1'b0;
    tx_data_d  = 8'h00;
    busy_d     = (state_d != IDLE);
    case (state_d)
      SEND_HDR: begin
        tx_valid_d = 1'b1;
        tx_data_d  = HEADER;
      end
      SEND_SEQ: begin
        tx_valid_d = 1'b1;
        tx_data_d  = frame_seq_d;
      end
      SEND_CH: begin
        tx_valid_d = 1'b1;
        tx_data_d  = snap_q[ch_idx_d];
      end
      default: begin
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end
    endcase
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_idx_q    <= '0;
      seq_no_q    <= 8'h00;
      frame_seq_q <= 8'h00;
      dropped_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_idx_q    <= ch_idx_d;
      seq_no_q    <= seq_no_d;
      frame_seq_q <= frame_seq_d;
      dropped_q   <= dropped_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
    end
  end

  // Snapshot of all channel counts, taken one edge after the strobe edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        snap_q[k] <= '0;
      end
    end else if (snap_load_s) begin
      for (int k = 0; k < NUM_CH; k++) begin
        snap_q[k] <= reg_count_flat[k*COUNT_W +: COUNT_W];
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        snap_q[k] <= snap_q[k];
      end
    end
  end

  assign batch_done = batch_done_s;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign dropped    = dropped_q;

endmodule
